// File: rtl/cpu_register_file.sv
`default_nettype none
// ============================================================================
// Module      : cpu_register_file
// Description : 2**ADDR_WIDTH x DATA_WIDTH register file, two async read ports,
//               one sync write port with same-cycle write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_address_0,
    input  logic [ADDR_WIDTH-1:0] read_address_1,
    input  logic [ADDR_WIDTH-1:0] write_address_0,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data_0,
    output logic [DATA_WIDTH-1:0] read_data_1
);

    localparam int C_NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [C_NUM_REGS];
    logic                  w_wr_live;

    // A write is live only outside reset; address 0 is never a valid target.
    assign w_wr_live = write_en && rst_n && (write_address_0 != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_regs <= '{default: '0};
        end else if (w_wr_live) begin
            r_regs[write_address_0] <= write_data;
        end
    end

    always_comb begin
        read_data_0 = r_regs[read_address_0];
        if (read_address_0 == '0) begin
            read_data_0 = '0;
        end else if (w_wr_live && (write_address_0 == read_address_0)) begin
            read_data_0 = write_data;
        end
    end

    always_comb begin
        read_data_1 = r_regs[read_address_1];
        if (read_address_1 == '0) begin
            read_data_1 = '0;
        end else if (w_wr_live && (write_address_0 == read_address_1)) begin
            read_data_1 = write_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu_register_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_register_file
// Description : Directed self-checking bench for cpu_register_file.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_register_file;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk;
    logic          rst_n;
    logic [AW-1:0] read_address_0;
    logic [AW-1:0] read_address_1;
    logic [AW-1:0] write_address_0;
    logic          write_en;
    logic [DW-1:0] write_data;
    logic [DW-1:0] read_data_0;
    logic [DW-1:0] read_data_1;

    int n_vec;
    int n_err;

    cpu_register_file #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .read_address_0 (read_address_0),
        .read_address_1 (read_address_1),
        .write_address_0(write_address_0),
        .write_en       (write_en),
        .write_data     (write_data),
        .read_data_0    (read_data_0),
        .read_data_1    (read_data_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one edge; inputs then change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        write_en        = 1'b1;
        write_address_0 = a;
        write_data      = d;
        tick();
        write_en        = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        write_en = 1'b0;
        write_address_0 = '0;
        write_data = '0;
        read_address_0 = '0;
        read_address_1 = '0;

        // Reset
        tick();
        tick();
        rst_n = 1'b1;
        read_address_0 = 5'd9;
        read_address_1 = 5'd13;
        #1;
        check("rst_rd0", read_data_0, 32'd0);
        check("rst_rd1", read_data_1, 32'd0);

        // Write/read and hold
        wr(5'd3, 32'd175);
        wr(5'd2, 32'd190);
        read_address_0 = 5'd3;
        read_address_1 = 5'd2;
        #1;
        check("wr_rd0", read_data_0, 32'd175);
        check("wr_rd1", read_data_1, 32'd190);
        for (int i = 0; i < 10; i++) tick();
        check("hold_rd0", read_data_0, 32'd175);
        check("hold_rd1", read_data_1, 32'd190);

        // Both ports on the same register
        read_address_1 = 5'd3;
        #1;
        check("same_rd1", read_data_1, 32'd175);

        // Highest address, neighbour untouched
        wr(5'd31, 32'hA5A5A5A5);
        read_address_0 = 5'd31;
        read_address_1 = 5'd30;
        #1;
        check("hi_rd0", read_data_0, 32'hA5A5A5A5);
        check("hi_rd1", read_data_1, 32'd0);

        // Zero register
        write_en = 1'b1;
        write_address_0 = 5'd0;
        write_data = 32'hDEADBEEF;
        read_address_0 = 5'd0;
        read_address_1 = 5'd0;
        #1;
        check("z_pre_rd0", read_data_0, 32'd0);
        check("z_pre_rd1", read_data_1, 32'd0);
        tick();
        write_en = 1'b0;
        #1;
        check("z_post_rd0", read_data_0, 32'd0);
        check("z_post_rd1", read_data_1, 32'd0);

        // Forwarding
        wr(5'd5, 32'd7);
        read_address_0 = 5'd5;
        #1;
        check("fw_base", read_data_0, 32'd7);
        write_en = 1'b1;
        write_address_0 = 5'd5;
        write_data = 32'd99;
        read_address_0 = 5'd5;
        read_address_1 = 5'd3;
        #1;
        check("fw_rd0", read_data_0, 32'd99);
        check("fw_other_rd1", read_data_1, 32'd175);
        read_address_1 = 5'd5;
        #1;
        check("fw_both_rd1", read_data_1, 32'd99);
        read_address_0 = 5'd6;
        #1;
        check("fw_nomatch_rd0", read_data_0, 32'd0);
        tick();
        write_en = 1'b0;
        read_address_0 = 5'd5;
        #1;
        check("fw_post_rd0", read_data_0, 32'd99);
        check("fw_post_rd1", read_data_1, 32'd99);

        // Write disabled
        write_en = 1'b0;
        write_address_0 = 5'd3;
        write_data = 32'd1;
        read_address_0 = 5'd3;
        #1;
        check("dis_nofw", read_data_0, 32'd175);
        for (int i = 0; i < 4; i++) tick();
        check("dis_rd0", read_data_0, 32'd175);

        // Reset mid-operation, with a concurrent write that must be dropped
        wr(5'd4, 32'h00001234);
        rst_n = 1'b0;
        write_en = 1'b1;
        write_address_0 = 5'd4;
        write_data = 32'd55;
        read_address_0 = 5'd4;
        read_address_1 = 5'd3;
        #1;
        check("rst_nofw_rd0", read_data_0, 32'h00001234);
        check("rst_pre_rd1", read_data_1, 32'd175);
        tick();
        rst_n = 1'b1;
        write_en = 1'b0;
        #1;
        check("rst_r4", read_data_0, 32'd0);
        check("rst_r3", read_data_1, 32'd0);
        for (int a = 0; a < 32; a++) begin
            read_address_0 = AW'(a);
            read_address_1 = AW'(31 - a);
            #1;
            check($sformatf("sweep0_%0d", a), read_data_0, 32'd0);
            check($sformatf("sweep1_%0d", 31 - a), read_data_1, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
